e203_exu_alu_shrsched: RTL

- Scheduler for the shared 35-bit ALU adder and the two 33-bit shared buffers (sbf_0/sbf_1) in the EXU.
- Three clients use these resources: the muldiv engine (multi-cycle, locking), the AGU (multi-cycle for AMO, locking) and the regular ALU (single-cycle, never locks).
- Decides ownership each cycle, muxes the owner's adder request onto the adder, and holds the sbf registers.
- Sits between the clients and e203_exu_alu_dpath.

---
 rtl/e203_exu_shrsched_pkg.sv | 23 ++
 rtl/e203_exu_shrsched_rr3.sv | 33 +++
 rtl/e203_exu_alu_shrsched.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/e203_exu_shrsched_pkg.sv
// Shared types and defaults for the EXU shared adder / sbf scheduler.
// Client indices double as bit positions in the grant vector.
package e203_exu_shrsched_pkg;

  localparam int DEF_ADD_W    = 35;
  localparam int DEF_SBF_W    = 33;
  localparam int DEF_LOCK_MAX = 40;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MDV_LOCK = 2'd1,
    AGU_LOCK = 2'd2
  } owner_e;

  localparam logic [1:0] MDV = 2'd0;
  localparam logic [1:0] AGU = 2'd1;
  localparam logic [1:0] ALU = 2'd2;

  function automatic logic [1:0] rr_follow(input logic [1:0] idx);
    return (idx == ALU) ? MDV : idx + 2'd1;
  endfunction

endpackage

// File: rtl/e203_exu_shrsched_rr3.sv
// 3-way round-robin arbiter: the client named by ptr has top priority,
// then the others in mdv -> agu -> alu order. Purely combinational.
module e203_exu_shrsched_rr3
  import e203_exu_shrsched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] ptr_nxt
);

  logic [2:0] sum;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt     = 3'b000;
    ptr_nxt = ptr;
    sum     = 3'd0;
    idx     = 2'd0;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, ptr} + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_nxt  = rr_follow(idx);
      end
    end
  end

endmodule

// File: rtl/e203_exu_alu_shrsched.sv
// Ownership scheduler for the shared ALU adder and the two shared buffers.
// Grants are combinational; ownership, rr pointer, lock timer and sbfs are flops.
module e203_exu_alu_shrsched
  import e203_exu_shrsched_pkg::*;
#(
  parameter int ADD_W    = DEF_ADD_W,
  parameter int SBF_W    = DEF_SBF_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_pulse,
  input  logic             mdv_req,
  input  logic             mdv_lock,
  input  logic [ADD_W-1:0] mdv_op1,
  input  logic [ADD_W-1:0] mdv_op2,
  input  logic             mdv_add,
  input  logic             mdv_sub,
  input  logic             mdv_sbf_0_ena,
  input  logic             mdv_sbf_1_ena,
  input  logic [SBF_W-1:0] mdv_sbf_0_nxt,
  input  logic [SBF_W-1:0] mdv_sbf_1_nxt,
  output logic             mdv_gnt,
  input  logic             agu_req,
  input  logic             agu_lock,
  input  logic [ADD_W-1:0] agu_op1,
  input  logic [ADD_W-1:0] agu_op2,
  input  logic             agu_add,
  input  logic             agu_sub,
  input  logic             agu_sbf_0_ena,
  input  logic             agu_sbf_1_ena,
  input  logic [SBF_W-1:0] agu_sbf_0_nxt,
  input  logic [SBF_W-1:0] agu_sbf_1_nxt,
  output logic             agu_gnt,
  input  logic             alu_req,
  input  logic [ADD_W-1:0] alu_op1,
  input  logic [ADD_W-1:0] alu_op2,
  input  logic             alu_add,
  input  logic             alu_sub,
  output logic             alu_gnt,
  output logic [ADD_W-1:0] adder_op1,
  output logic [ADD_W-1:0] adder_op2,
  output logic             adder_add,
  output logic             adder_sub,
  output logic [SBF_W-1:0] sbf_0_r,
  output logic [SBF_W-1:0] sbf_1_r,
  output logic [1:0]       owner,
  output logic             lock_tmo
);

  localparam int               CNT_W   = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_MAX);

  owner_e           owner_q, owner_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [SBF_W-1:0] sbf_0_q, sbf_0_d, sbf_1_q, sbf_1_d;
  logic [2:0]       rr_gnt, gnt;
  logic [1:0]       rr_ptr_nxt;

  e203_exu_shrsched_rr3 u_rr3 (
    .req     ({alu_req, agu_req, mdv_req}),
    .ptr     (rr_ptr_q),
    .gnt     (rr_gnt),
    .ptr_nxt (rr_ptr_nxt)
  );

  always_comb begin
    gnt = 3'b000;
    if (!flush_pulse) begin
      case (owner_q)
        IDLE:     gnt = rr_gnt;
        MDV_LOCK: gnt[MDV] = mdv_req;
        AGU_LOCK: gnt[AGU] = agu_req;
        default:  gnt = 3'b000;
      endcase
    end
  end

  // A locked owner idling with req low keeps the lock and keeps the timer running.
  always_comb begin
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    if (flush_pulse) begin
      owner_d    = IDLE;
      lock_cnt_d = '0;
    end else begin
      case (owner_q)
        IDLE: begin
          lock_cnt_d = '0;
          if (|gnt) rr_ptr_d = rr_ptr_nxt;
          if (gnt[MDV] && mdv_lock)      owner_d = MDV_LOCK;
          else if (gnt[AGU] && agu_lock) owner_d = AGU_LOCK;
        end
        MDV_LOCK, AGU_LOCK: begin
          if ((gnt[MDV] && !mdv_lock) || (gnt[AGU] && !agu_lock)) begin
            owner_d    = IDLE;
            lock_cnt_d = '0;
          end else if (lock_cnt_q != CNT_MAX) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        default: begin
          owner_d    = IDLE;
          lock_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    sbf_0_d = sbf_0_q;
    sbf_1_d = sbf_1_q;
    if (gnt[MDV] && mdv_sbf_0_ena)      sbf_0_d = mdv_sbf_0_nxt;
    else if (gnt[AGU] && agu_sbf_0_ena) sbf_0_d = agu_sbf_0_nxt;
    if (gnt[MDV] && mdv_sbf_1_ena)      sbf_1_d = mdv_sbf_1_nxt;
    else if (gnt[AGU] && agu_sbf_1_ena) sbf_1_d = agu_sbf_1_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= IDLE;
      rr_ptr_q   <= MDV;
      lock_cnt_q <= '0;
      sbf_0_q    <= '0;
      sbf_1_q    <= '0;
    end else begin
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      sbf_0_q    <= sbf_0_d;
      sbf_1_q    <= sbf_1_d;
    end
  end

  assign adder_op1 = ({ADD_W{gnt[MDV]}} & mdv_op1) | ({ADD_W{gnt[AGU]}} & agu_op1)
                   | ({ADD_W{gnt[ALU]}} & alu_op1);
  assign adder_op2 = ({ADD_W{gnt[MDV]}} & mdv_op2) | ({ADD_W{gnt[AGU]}} & agu_op2)
                   | ({ADD_W{gnt[ALU]}} & alu_op2);
  assign adder_add = (gnt[MDV] & mdv_add) | (gnt[AGU] & agu_add) | (gnt[ALU] & alu_add);
  assign adder_sub = (gnt[MDV] & mdv_sub) | (gnt[AGU] & agu_sub) | (gnt[ALU] & alu_sub);

  assign mdv_gnt  = gnt[MDV];
  assign agu_gnt  = gnt[AGU];
  assign alu_gnt  = gnt[ALU];
  assign sbf_0_r  = sbf_0_q;
  assign sbf_1_r  = sbf_1_q;
  assign owner    = owner_q;
  assign lock_tmo = (lock_cnt_q == CNT_MAX);

endmodule
